// File: rtl/addr_ctrl_pipe.sv
// Address controller: selects one of NSRC sources or steps an internal pointer, then
// delays the result through a DEPTH-stage pipeline with valid and wrap tracking.
module addr_ctrl_pipe #(
  parameter int unsigned AW    = 4,
  parameter int unsigned NSRC  = 2,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned STEP  = 1,
  localparam int unsigned SELW = $clog2(NSRC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NSRC*AW-1:0] src,
  input  logic [SELW-1:0]    sel,
  input  logic [1:0]         mode,
  input  logic               cmd_vld,
  input  logic               en,
  output logic [AW-1:0]      addr,
  output logic               addr_vld,
  output logic               wrap
);

  localparam logic [AW:0] StepExt = (AW+1)'(STEP);

  // Stage 0 of these arrays is the pointer itself; stage DEPTH-1 drives the outputs.
  logic [AW-1:0]    addr_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] wrap_q;

  logic [AW-1:0] load_val;
  logic [AW:0]   sum;
  logic [AW:0]   diff;
  logic [AW-1:0] ptr_d;
  logic          wrap_d;

  always_comb begin
    // Out-of-range select falls through to zero.
    load_val = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      if (sel == SELW'(i)) load_val = src[i*AW +: AW];
    end
    sum    = {1'b0, addr_q[0]} + StepExt;
    diff   = {1'b0, addr_q[0]} - StepExt;
    ptr_d  = addr_q[0];
    wrap_d = 1'b0;
    if (cmd_vld) begin
      case (mode)
        2'b00: ptr_d = load_val;
        2'b01: begin
          ptr_d  = sum[AW-1:0];
          wrap_d = sum[AW];
        end
        2'b10: begin
          ptr_d  = diff[AW-1:0];
          wrap_d = diff[AW];
        end
        default: ptr_d = addr_q[0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) addr_q[i] <= '0;
      vld_q  <= '0;
      wrap_q <= '0;
    end else if (en) begin
      addr_q[0] <= ptr_d;
      vld_q[0]  <= cmd_vld;
      wrap_q[0] <= wrap_d;
      for (int i = 1; i < int'(DEPTH); i++) begin
        addr_q[i] <= addr_q[i-1];
        vld_q[i]  <= vld_q[i-1];
        wrap_q[i] <= wrap_q[i-1];
      end
    end
  end

  assign addr     = addr_q[DEPTH-1];
  assign addr_vld = vld_q[DEPTH-1];
  assign wrap     = wrap_q[DEPTH-1];

endmodule

// File: tb/tb_addr_ctrl_pipe.sv
// Bench for addr_ctrl_pipe: two configurations driven in parallel, checked against a
// queue-based latency model plus directed scenarios with fixed expected values.
module tb_addr_ctrl_pipe;

  typedef struct packed {
    logic [3:0] a;
    logic       v;
    logic       w;
  } res_t;

  localparam int DepA = 2;
  localparam int DepB = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [11:0] src = '0;
  logic [1:0]  sel = '0;
  logic [1:0]  mode = '0;
  logic        cmd_vld = 1'b0;
  logic        en = 1'b1;

  logic [3:0] addr_a, addr_b;
  logic       vld_a, vld_b, wrap_a, wrap_b;

  int checks = 0;
  int errors = 0;

  res_t q_a[$];
  res_t q_b[$];
  int   ptr_a, ptr_b;

  always #5 clk = ~clk;

  addr_ctrl_pipe #(.AW(4), .NSRC(2), .DEPTH(DepA), .STEP(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .src(src[7:0]), .sel(sel[0]), .mode(mode),
    .cmd_vld(cmd_vld), .en(en), .addr(addr_a), .addr_vld(vld_a), .wrap(wrap_a)
  );

  addr_ctrl_pipe #(.AW(4), .NSRC(3), .DEPTH(DepB), .STEP(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .src(src), .sel(sel), .mode(mode),
    .cmd_vld(cmd_vld), .en(en), .addr(addr_b), .addr_vld(vld_b), .wrap(wrap_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Result of one accepted command, from the arithmetic rules directly.
  function automatic res_t next_res(input int ptr, input int nsrc, input int step,
                                    input int sel_v, input logic [11:0] srcv,
                                    input logic [1:0] md, input logic cv,
                                    output int ptr_n);
    res_t r;
    r     = '0;
    ptr_n = ptr;
    if (cv) begin
      r.v = 1'b1;
      case (md)
        2'd0: ptr_n = (sel_v < nsrc) ? int'((srcv >> (4 * sel_v)) & 12'hF) : 0;
        2'd1: begin
          ptr_n = ptr + step;
          if (ptr_n >= 16) begin
            r.w   = 1'b1;
            ptr_n = ptr_n - 16;
          end
        end
        2'd2: begin
          if (ptr < step) begin
            r.w   = 1'b1;
            ptr_n = ptr - step + 16;
          end else begin
            ptr_n = ptr - step;
          end
        end
        default: ptr_n = ptr;
      endcase
    end
    r.a = 4'(ptr_n);
    return r;
  endfunction

  task automatic model_reset();
    q_a.delete();
    q_b.delete();
    for (int i = 0; i < DepA; i++) q_a.push_back('0);
    for (int i = 0; i < DepB; i++) q_b.push_back('0);
    ptr_a = 0;
    ptr_b = 0;
  endtask

  task automatic check_model();
    check_eq("model_a", {addr_a, vld_a, wrap_a}, q_a[0]);
    check_eq("model_b", {addr_b, vld_b, wrap_b}, q_b[0]);
  endtask

  // One rising edge: advance the model with the sampled inputs, then compare.
  task automatic cycle();
    res_t r;
    int   p;
    @(posedge clk);
    if (en) begin
      r = next_res(ptr_a, 2, 1, int'(sel[0]), src, mode, cmd_vld, p);
      ptr_a = p;
      void'(q_a.pop_front());
      q_a.push_back(r);
      r = next_res(ptr_b, 3, 3, int'(sel), src, mode, cmd_vld, p);
      ptr_b = p;
      void'(q_b.pop_front());
      q_b.push_back(r);
    end
    #1;
    check_model();
  endtask

  task automatic issue(input logic [1:0] md, input logic [1:0] s, input logic [11:0] sv,
                       input logic cv, input logic e);
    mode    = md;
    sel     = s;
    src     = sv;
    cmd_vld = cv;
    en      = e;
    cycle();
  endtask

  task automatic idle();
    issue(2'd3, 2'd0, 12'h000, 1'b0, 1'b1);
  endtask

  initial begin
    // Asynchronous reset, observed before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_async_a", {addr_a, vld_a, wrap_a}, 6'h00);
    check_eq("rst_async_b", {addr_b, vld_b, wrap_b}, 6'h00);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Load sel=1, src1=0xA: visible exactly two edges later on the DEPTH=2 instance.
    issue(2'd0, 2'd1, 12'h0A0, 1'b1, 1'b1);
    check_eq("load_lat1_vld", vld_a, 1'b0);
    idle();
    check_eq("load_a", {addr_a, vld_a}, {4'hA, 1'b1});

    // Increment wrap on the STEP=1 instance.
    issue(2'd0, 2'd1, 12'h0E0, 1'b1, 1'b1);
    issue(2'd1, 2'd0, 12'h000, 1'b1, 1'b1);
    check_eq("inc_e", {addr_a, vld_a, wrap_a}, {4'hE, 1'b1, 1'b0});
    issue(2'd1, 2'd0, 12'h000, 1'b1, 1'b1);
    check_eq("inc_f", {addr_a, vld_a, wrap_a}, {4'hF, 1'b1, 1'b0});
    issue(2'd1, 2'd0, 12'h000, 1'b1, 1'b1);
    check_eq("inc_wrap", {addr_a, vld_a, wrap_a}, {4'h0, 1'b1, 1'b1});
    idle();
    check_eq("inc_after", {addr_a, vld_a, wrap_a}, {4'h1, 1'b1, 1'b0});

    // Decrement borrow on the STEP=3, DEPTH=3 instance.
    issue(2'd0, 2'd1, 12'h222, 1'b1, 1'b1);
    issue(2'd2, 2'd0, 12'h000, 1'b1, 1'b1);
    issue(2'd2, 2'd0, 12'h000, 1'b1, 1'b1);
    check_eq("dec_load", {addr_b, vld_b, wrap_b}, {4'h2, 1'b1, 1'b0});
    idle();
    check_eq("dec_borrow", {addr_b, vld_b, wrap_b}, {4'hF, 1'b1, 1'b1});
    idle();
    check_eq("dec_second", {addr_b, vld_b, wrap_b}, {4'hC, 1'b1, 1'b0});

    // Stall: load 5, inc, two stalled edges, inc.
    issue(2'd0, 2'd1, 12'h050, 1'b1, 1'b1);
    issue(2'd1, 2'd0, 12'h000, 1'b1, 1'b1);
    check_eq("stall_load", {addr_a, vld_a}, {4'h5, 1'b1});
    issue(2'd1, 2'd0, 12'h000, 1'b1, 1'b0);
    check_eq("stall_hold1", {addr_a, vld_a}, {4'h5, 1'b1});
    issue(2'd0, 2'd0, 12'hFFF, 1'b1, 1'b0);
    check_eq("stall_hold2", {addr_a, vld_a}, {4'h5, 1'b1});
    issue(2'd1, 2'd0, 12'h000, 1'b1, 1'b1);
    check_eq("stall_inc1", {addr_a, vld_a}, {4'h6, 1'b1});
    idle();
    check_eq("stall_inc2", {addr_a, vld_a}, {4'h7, 1'b1});

    // Bubbles alternate with a three-edge lag on the DEPTH=3 instance.
    for (int i = 0; i < 6; i++) issue(2'd3, 2'd0, 12'h000, (i % 2) == 0, 1'b1);
    check_eq("bubble_vld", vld_b, 1'b0);

    // Out-of-range select on NSRC=3.
    issue(2'd0, 2'd3, 12'hFFF, 1'b1, 1'b1);
    idle();
    idle();
    check_eq("sel_oor", {addr_b, vld_b}, {4'h0, 1'b1});

    // Mid-flight reset between edges.
    issue(2'd0, 2'd1, 12'h090, 1'b1, 1'b1);
    issue(2'd0, 2'd2, 12'h700, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_a", {addr_a, vld_a, wrap_a}, 6'h00);
    check_eq("midrst_b", {addr_b, vld_b, wrap_b}, 6'h00);
    model_reset();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) idle();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      issue(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 12'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
